div_pipe_signed: RTL and testbench

//  Parametrised, fully pipelined signed integer divider with a valid/tag sideband and a pipeline stall input.

---
 rtl/div_pipe_signed_pkg.sv | 27 ++
 rtl/div_pipe_signed_if.sv | 32 +++
 rtl/div_pipe_signed_stage.sv | 48 ++++
 rtl/div_pipe_signed.sv | 145 ++++++++++++++
 tb/tb_div_pipe_signed.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pipe_signed_pkg.sv
// rtl/div_pipe_signed_pkg.sv - shared stage record, latency function and default widths for the signed divider
package gpu_div_pkg;

    localparam int DIV_NUM_W = 32;
    localparam int DIV_DEN_W = 22;
    localparam int DIV_OUT_W = 20;
    localparam int DIV_BPS   = 4;
    localparam int DIV_TAG_W = 4;

    // One pipeline slot: rem is the partial remainder, quot starts as |num| and
    // is shifted left one bit per iteration while quotient bits enter at the LSB.
    // NUM_W unsigned bits hold |-2^(NUM_W-1)| exactly.
    typedef struct packed {
        logic                 valid;
        logic [DIV_TAG_W-1:0] tag;
        logic                 sign;
        logic                 div0;
        logic [DIV_NUM_W-1:0] rem;
        logic [DIV_NUM_W-1:0] quot;
        logic [DIV_NUM_W-1:0] den;
    } div_rec_t;

    function automatic int div_lat(input int num_w, input int bps);
        return num_w / bps + 2;
    endfunction

endpackage

// File: rtl/div_pipe_signed_if.sv
// rtl/div_pipe_signed_if.sv - operand and result bundle of the signed pipelined divider
interface div_pipe_signed_if
    import gpu_div_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W,
    parameter int OUT_W = DIV_OUT_W,
    parameter int TAG_W = DIV_TAG_W
) ();

    logic             i_ce;
    logic             i_valid;
    logic [TAG_W-1:0] i_tag;
    logic [NUM_W-1:0] i_num;
    logic [DEN_W-1:0] i_den;
    logic             o_valid;
    logic [TAG_W-1:0] o_tag;
    logic [OUT_W-1:0] o_quot;
    logic             o_div0;
    logic             o_ovf;

    modport master (
        output i_ce, i_valid, i_tag, i_num, i_den,
        input  o_valid, o_tag, o_quot, o_div0, o_ovf
    );

    modport slave (
        input  i_ce, i_valid, i_tag, i_num, i_den,
        output o_valid, o_tag, o_quot, o_div0, o_ovf
    );

endinterface

// File: rtl/div_pipe_signed_stage.sv
// rtl/div_pipe_signed_stage.sv - one registered stage resolving BPS quotient bits by restoring division
module div_pipe_stage
    import gpu_div_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int BPS   = DIV_BPS
) (
    input  logic     clock,
    input  logic     nRst,
    input  logic     i_ce,
    input  div_rec_t i_rec,
    output div_rec_t o_rec
);

    logic [NUM_W-1:0] w_rem;
    logic [NUM_W-1:0] w_quot;
    logic [NUM_W:0]   w_trial;

    // BPS restoring iterations, MSB of the remaining dividend first
    always_comb begin
        w_rem   = i_rec.rem;
        w_quot  = i_rec.quot;
        w_trial = '0;
        for (int i = 0; i < BPS; i++) begin
            w_trial = {w_rem, w_quot[NUM_W-1]};
            if (w_trial >= {1'b0, i_rec.den}) begin
                // true difference is below den, so NUM_W-bit wraparound is exact
                w_rem  = w_trial[NUM_W-1:0] - i_rec.den;
                w_quot = {w_quot[NUM_W-2:0], 1'b1};
            end else begin
                w_rem  = w_trial[NUM_W-1:0];
                w_quot = {w_quot[NUM_W-2:0], 1'b0};
            end
        end
    end

    // stage register; the whole record, valid included, freezes while i_ce is low
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            o_rec <= '0;
        end else if (i_ce) begin
            o_rec      <= i_rec;
            o_rec.rem  <= w_rem;
            o_rec.quot <= w_quot;
        end
    end

endmodule

// File: rtl/div_pipe_signed.sv
// rtl/div_pipe_signed.sv - fully pipelined signed divider top; DIV_SAT_EN selects saturating output
module div_pipe_signed
    import gpu_div_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W,
    parameter int OUT_W = DIV_OUT_W,
    parameter int BPS   = DIV_BPS,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clock,
    input  logic             nRst,
    div_pipe_signed_if.slave bus
);

    localparam int NSTG = NUM_W / BPS;

    if (NUM_W % BPS != 0) begin : g_chk_bps
        $error("div_pipe_signed: NUM_W must be a multiple of BPS");
    end
    if (DEN_W > NUM_W) begin : g_chk_den
        $error("div_pipe_signed: DEN_W must not exceed NUM_W");
    end
    if (OUT_W > NUM_W + 1) begin : g_chk_out
        $error("div_pipe_signed: OUT_W must not exceed NUM_W+1");
    end
    if (NUM_W != DIV_NUM_W || TAG_W != DIV_TAG_W) begin : g_chk_rec
        $error("div_pipe_signed: NUM_W/TAG_W must match the stage record widths in gpu_div_pkg");
    end

    logic [NUM_W-1:0] w_num;
    logic [NUM_W-1:0] w_den_sx;
    logic [NUM_W-1:0] w_num_abs;
    logic [NUM_W-1:0] w_den_abs;
    div_rec_t         w_s0;
    div_rec_t         r_s0;
    div_rec_t         w_chain [0:NSTG];

    assign w_num    = bus.i_num;
    assign w_den_sx = NUM_W'($signed(bus.i_den));

    // input stage: magnitudes, result sign and divide-by-zero detection
    always_comb begin
        w_num_abs = w_num[NUM_W-1]    ? -w_num    : w_num;
        w_den_abs = w_den_sx[NUM_W-1] ? -w_den_sx : w_den_sx;
        w_s0       = '0;
        w_s0.valid = bus.i_valid;
        w_s0.tag   = bus.i_tag;
        w_s0.sign  = w_num[NUM_W-1] ^ w_den_sx[NUM_W-1];
        w_s0.div0  = (bus.i_den == '0);
        w_s0.rem   = '0;
        w_s0.quot  = w_num_abs;
        w_s0.den   = w_den_abs;
    end

    // input stage register
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            r_s0 <= '0;
        end else if (bus.i_ce) begin
            r_s0 <= w_s0;
        end
    end

    assign w_chain[0] = r_s0;

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        div_pipe_stage #(
            .NUM_W (NUM_W),
            .BPS   (BPS)
        ) u_stage (
            .clock (clock),
            .nRst  (nRst),
            .i_ce  (bus.i_ce),
            .i_rec (w_chain[g]),
            .o_rec (w_chain[g+1])
        );
    end

    div_rec_t              w_last;
    logic signed [NUM_W:0] w_q_full;
    logic [OUT_W-1:0]      w_q_out;
    logic                  w_ovf;

    assign w_last = w_chain[NSTG];

`ifdef DIV_SAT_EN
    localparam logic signed [NUM_W:0] Q_MAX = {{(NUM_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [NUM_W:0] Q_MIN = ~Q_MAX;
`endif

    // output stage: apply sign to the exact quotient, then clamp or wrap into OUT_W
    always_comb begin
        w_q_full = w_last.sign ? -$signed({1'b0, w_last.quot}) : $signed({1'b0, w_last.quot});
`ifdef DIV_SAT_EN
        if (w_q_full > Q_MAX) begin
            w_q_out = Q_MAX[OUT_W-1:0];
            w_ovf   = 1'b1;
        end else if (w_q_full < Q_MIN) begin
            w_q_out = Q_MIN[OUT_W-1:0];
            w_ovf   = 1'b1;
        end else begin
            w_q_out = OUT_W'(w_q_full);
            w_ovf   = 1'b0;
        end
`else
        w_q_out = OUT_W'(w_q_full);
        w_ovf   = 1'b0;
`endif
        if (w_last.div0) begin
            w_q_out = '0;
            w_ovf   = 1'b0;
        end
    end

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [OUT_W-1:0] r_quot;
    logic             r_div0;
    logic             r_ovf;

    // output register
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_quot  <= '0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.i_ce) begin
            r_valid <= w_last.valid;
            r_tag   <= w_last.tag;
            r_quot  <= w_q_out;
            r_div0  <= w_last.div0;
            r_ovf   <= w_ovf;
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_tag   = r_tag;
    assign bus.o_quot  = r_quot;
    assign bus.o_div0  = r_div0;
    assign bus.o_ovf   = r_ovf;

endmodule

// File: tb/tb_div_pipe_signed.sv
// tb/tb_div_pipe_signed.sv - directed self-checking bench for div_pipe_signed
module tb_div_pipe_signed;

    logic clock = 1'b0;
    logic nRst;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    div_pipe_signed_if bus ();

    div_pipe_signed dut (
        .clock (clock),
        .nRst  (nRst),
        .bus   (bus)
    );

    int t_num [16] = '{100, -100, 100, -100, 0, 7, -7, 1000000, -1000000, 524287, -524288,
                       2147483647, int'(32'h80000000), 123456789, -2000000000, 65535};
    int t_den [16] = '{7, 7, -7, -7, 5, 100, 100, 3, 3, 1, 1, 4096, 4096, 2097151, -2097152, -255};
    int t_q   [16] = '{14, -14, -14, 14, 0, 0, 0, 333333, -333333, 524287, -524288,
                       524287, -524288, 58, 953, -257};

    task automatic issue_one(input int num, input int den, input logic [3:0] tag,
                             output int lat, output logic [19:0] q, output logic d0,
                             output logic ov, output logic [3:0] tg);
        int n;
        @(negedge clock);
        bus.i_ce    = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_num   = 32'(num);
        bus.i_den   = 22'(den);
        bus.i_tag   = tag;
        @(negedge clock);
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        lat = n;
        q   = bus.o_quot;
        d0  = bus.o_div0;
        ov  = bus.o_ovf;
        tg  = bus.o_tag;
    endtask

    task automatic test_reset;
        nRst        = 1'b0;
        bus.i_ce    = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_tag   = '0;
        bus.i_num   = '0;
        bus.i_den   = '0;
        repeat (3) @(negedge clock);
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        total++; if (bus.o_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%h exp=0", bus.o_tag); end
        total++; if (bus.o_quot !== 20'h0) begin bad++; $display("FAIL reset_quot got=%h exp=0", bus.o_quot); end
        total++; if (bus.o_div0 !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b exp=0", bus.o_div0); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.o_ovf); end
        nRst = 1'b1;
        bus.i_ce = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_signs;
        int lat; logic [19:0] q; logic d0, ov; logic [3:0] tg; logic [19:0] exp_q;
        for (int i = 0; i < 4; i++) begin
            issue_one(t_num[i], t_den[i], 4'(i + 1), lat, q, d0, ov, tg);
            exp_q = 20'(t_q[i]);
            total++; if (lat != 10) begin bad++; $display("FAIL sign%0d_latency got=%0d exp=10", i, lat); end
            total++; if (q !== exp_q) begin bad++; $display("FAIL sign%0d_quot got=%h exp=%h", i, q, exp_q); end
            total++; if (tg !== 4'(i + 1)) begin bad++; $display("FAIL sign%0d_tag got=%h exp=%h", i, tg, 4'(i + 1)); end
            total++; if (d0 !== 1'b0) begin bad++; $display("FAIL sign%0d_div0 got=%b exp=0", i, d0); end
        end
    endtask

    task automatic test_stream(input bit stall);
        int issued = 0;
        int got = 0;
        int cyc = 0;
        int extra = 0;
        int idx;
        bit hold;
        logic [19:0] exp_q;
        bus.i_valid = 1'b0;
        bus.i_ce    = 1'b1;
        while (got < 64 && cyc < 3000) begin
            @(negedge clock);
            if (bus.i_ce && bus.i_valid) issued++;
            hold = bus.i_valid && !bus.i_ce && (issued < 64);
            bus.i_ce    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_valid = (issued < 64) && (hold || !stall || ($urandom_range(0, 1) == 1));
            idx         = (issued * 5) % 16;
            bus.i_num   = 32'(t_num[idx]);
            bus.i_den   = 22'(t_den[idx]);
            bus.i_tag   = 4'(issued);
            if (bus.o_valid && bus.i_ce) begin
                idx   = (got * 5) % 16;
                exp_q = 20'(t_q[idx]);
                total++; if (bus.o_tag !== 4'(got)) begin bad++; $display("FAIL stream%0d_tag op=%0d got=%h exp=%h", stall, got, bus.o_tag, 4'(got)); end
                total++; if (bus.o_quot !== exp_q) begin bad++; $display("FAIL stream%0d_quot op=%0d got=%h exp=%h", stall, got, bus.o_quot, exp_q); end
                got++;
            end
            cyc++;
        end
        total++; if (got != 64) begin bad++; $display("FAIL stream%0d_count got=%0d exp=64", stall, got); end
        bus.i_ce    = 1'b1;
        bus.i_valid = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.o_valid) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL stream%0d_duplicates got=%0d exp=0", stall, extra); end
    endtask

    task automatic test_div0;
        int lat; logic [19:0] q; logic d0, ov; logic [3:0] tg;
        issue_one(12345, 0, 4'h3, lat, q, d0, ov, tg);
        total++; if (d0 !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b exp=1", d0); end
        total++; if (q !== 20'h0) begin bad++; $display("FAIL div0_quot got=%h exp=0", q); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL div0_ovf got=%b exp=0", ov); end
        issue_one(9, 3, 4'h4, lat, q, d0, ov, tg);
        total++; if (d0 !== 1'b0) begin bad++; $display("FAIL after_div0_flag got=%b exp=0", d0); end
        total++; if (q !== 20'h3) begin bad++; $display("FAIL after_div0_quot got=%h exp=3", q); end
        total++; if (lat != 10) begin bad++; $display("FAIL after_div0_latency got=%0d exp=10", lat); end
    endtask

    task automatic test_ovf;
        int lat; logic [19:0] q; logic d0, ov; logic [3:0] tg;
        int          v_num [5] = '{int'(32'h80000000), 1048576, -1048576, 524287, -524288};
        int          v_den [5] = '{-1, 1, 1, 1, 1};
`ifdef DIV_SAT_EN
        logic [19:0] v_q   [5] = '{20'h7FFFF, 20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000};
        logic        v_ov  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        logic [19:0] v_q   [5] = '{20'h00000, 20'h00000, 20'h00000, 20'h7FFFF, 20'h80000};
        logic        v_ov  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            issue_one(v_num[i], v_den[i], 4'(i + 8), lat, q, d0, ov, tg);
            total++; if (q !== v_q[i]) begin bad++; $display("FAIL ovf%0d_quot got=%h exp=%h", i, q, v_q[i]); end
            total++; if (ov !== v_ov[i]) begin bad++; $display("FAIL ovf%0d_flag got=%b exp=%b", i, ov, v_ov[i]); end
        end
    endtask

    task automatic test_reset_flight;
        int lat; logic [19:0] q; logic d0, ov; logic [3:0] tg;
        int seen = 0;
        @(negedge clock);
        bus.i_ce    = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_num   = 32'd1000;
        bus.i_den   = 22'd10;
        bus.i_tag   = 4'hF;
        for (int n = 1; n < 10; n++) begin
            @(negedge clock);
            bus.i_valid = (n >= 4 && n <= 8);
            bus.i_num   = 32'(200 * n);
            bus.i_den   = 22'd2;
            bus.i_tag   = 4'(n);
        end
        @(negedge clock);
        total++; if (bus.o_valid !== 1'b1 || bus.o_quot !== 20'd100 || bus.o_tag !== 4'hF) begin
            bad++; $display("FAIL preflight_result got=%b/%h/%h exp=1/00064/f", bus.o_valid, bus.o_quot, bus.o_tag);
        end
        nRst = 1'b0;
        #1;
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL flight_reset_valid got=%b exp=0", bus.o_valid); end
        total++; if (bus.o_quot !== 20'h0) begin bad++; $display("FAIL flight_reset_quot got=%h exp=0", bus.o_quot); end
        total++; if (bus.o_tag !== 4'h0) begin bad++; $display("FAIL flight_reset_tag got=%h exp=0", bus.o_tag); end
        bus.i_ce = 1'b0;
        repeat (2) @(negedge clock);
        nRst = 1'b1;
        @(negedge clock);
        bus.i_ce = 1'b1;
        repeat (30) begin
            @(negedge clock);
            if (bus.o_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flight_discard got=%0d exp=0", seen); end
        issue_one(-77, 7, 4'h9, lat, q, d0, ov, tg);
        total++; if (lat != 10) begin bad++; $display("FAIL post_reset_latency got=%0d exp=10", lat); end
        total++; if (q !== 20'hFFFF5) begin bad++; $display("FAIL post_reset_quot got=%h exp=ffff5", q); end
        total++; if (tg !== 4'h9) begin bad++; $display("FAIL post_reset_tag got=%h exp=9", tg); end
    endtask

    initial begin
        test_reset;
        test_signs;
        test_stream(1'b0);
        test_stream(1'b1);
        test_div0;
        test_ovf;
        test_reset_flight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
